// File: rtl/bt_hdr_rx_multi.sv
// BR/EDR packet-header receiver: FEC majority vote, de-whitening, HEC check and per-LT_ADDR
// FLOW/ARQN/SEQN tracking. Define BT_HDR_FEC_ERRCNT_EN to enable the fec_errcnt counter.
module bt_hdr_rx_multi #(
  parameter int         NUM_LT   = 8,
  parameter int         FEC_REP  = 3,
  parameter logic [7:0] HEC_POLY = 8'hA7
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              p_1us,
  input  logic              header_st_p,
  input  logic              rx_abort,
  input  logic              rxbit,
  input  logic              whiten_en,
  input  logic [5:0]        clk_seed,
  input  logic [7:0]        uap,
  input  logic [2:0]        ms_lt_addr,
  output logic              busy,
  output logic              hdr_done_p,
  output logic              hdr_good_p,
  output logic              lt_addressed,
  output logic [2:0]        rx_lt_addr,
  output logic [3:0]        rx_type,
  output logic              rx_is_null,
  output logic              rx_is_poll,
  output logic              rx_is_fhs,
  output logic              rx_seqn,
  output logic [NUM_LT-1:0] flow_vec,
  output logic [NUM_LT-1:0] arqn_vec,
  output logic [NUM_LT-1:0] seqn_vec,
  output logic [NUM_LT-1:0] flow_stop_start_p,
  output logic [7:0]        fec_errcnt
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_CHECK} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_rep_cnt, r_ones, w_ones_tot;
  logic [4:0]  r_bit_cnt;
  logic [6:0]  r_lfsr;
  logic [7:0]  r_hec;
  logic        r_hec_err;
  logic [9:0]  r_hold;
  logic        w_start, w_sample, w_wrap, w_vote, w_bit, w_exit, w_good;

  logic              r_done_p, r_good_p, r_addr_hit, r_rx_seqn;
  logic              r_is_null, r_is_poll, r_is_fhs;
  logic [2:0]        r_rx_lt;
  logic [3:0]        r_rx_type;
  logic [NUM_LT-1:0] r_flow, r_arqn, r_seqn, r_fss_p;

  // A start pulse in CHECK is ignored; abort always wins.
  assign w_start    = header_st_p && !rx_abort && (r_state != S_CHECK);
  assign w_sample   = (r_state == S_HDR) && p_1us && !header_st_p && !rx_abort;
  assign w_wrap     = w_sample && (r_rep_cnt == 3'(FEC_REP - 1));
  assign w_ones_tot = r_ones + {2'b00, rxbit};
  assign w_vote     = (w_ones_tot > 3'(FEC_REP / 2));
  assign w_bit      = w_vote ^ (whiten_en & r_lfsr[6]);
  assign w_exit     = (r_state == S_CHECK) && p_1us && !rx_abort;
  assign w_good     = !r_hec_err;

  always_ff @(posedge clk_6M or negedge rstz) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstz) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (rx_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (header_st_p) w_state_nxt = S_HDR;
        S_HDR:   if (!header_st_p && w_wrap && (r_bit_cnt == 5'd17)) w_state_nxt = S_CHECK;
        S_CHECK: if (p_1us) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_rep_cnt <= '0;
      r_ones    <= '0;
      r_bit_cnt <= '0;
      r_lfsr    <= '0;
      r_hec     <= '0;
      r_hec_err <= 1'b0;
      r_hold    <= '0;
    end else if (w_start) begin
      r_rep_cnt <= '0;
      r_ones    <= '0;
      r_bit_cnt <= '0;
      r_lfsr    <= {1'b1, clk_seed};
      r_hec     <= uap;
      r_hec_err <= 1'b0;
    end else if (w_wrap) begin
      r_rep_cnt <= '0;
      r_ones    <= '0;
      r_bit_cnt <= r_bit_cnt + 5'd1;
      r_lfsr    <= {r_lfsr[5:4], r_lfsr[3] ^ r_lfsr[6], r_lfsr[2:0], r_lfsr[6]};
      if (r_bit_cnt < 5'd10) begin
        r_hold <= {w_bit, r_hold[9:1]};
        r_hec  <= {r_hec[6:0], 1'b0} ^ ((w_bit ^ r_hec[7]) ? HEC_POLY : 8'h00);
      end else begin
        // Received HEC arrives MSB of the remainder first; shift it past r_hec[7].
        r_hec <= {r_hec[6:0], 1'b0};
        if (w_bit != r_hec[7]) r_hec_err <= 1'b1;
      end
    end else if (w_sample) begin
      r_rep_cnt <= r_rep_cnt + 3'd1;
      r_ones    <= w_ones_tot;
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_done_p   <= 1'b0;
      r_good_p   <= 1'b0;
      r_addr_hit <= 1'b0;
      r_rx_lt    <= '0;
      r_rx_type  <= '0;
      r_rx_seqn  <= 1'b0;
      r_is_null  <= 1'b0;
      r_is_poll  <= 1'b0;
      r_is_fhs   <= 1'b0;
      r_flow     <= '1;
      r_arqn     <= '0;
      r_seqn     <= '0;
      r_fss_p    <= '0;
    end else begin
      r_done_p <= 1'b0;
      r_good_p <= 1'b0;
      r_fss_p  <= '0;
      if (rx_abort || header_st_p) r_addr_hit <= 1'b0;
      if (w_exit) begin
        r_done_p   <= 1'b1;
        r_good_p   <= w_good;
        r_rx_lt    <= r_hold[2:0];
        r_rx_type  <= r_hold[6:3];
        r_rx_seqn  <= r_hold[9];
        r_is_null  <= (r_hold[6:3] == 4'd0);
        r_is_poll  <= (r_hold[6:3] == 4'd1);
        r_is_fhs   <= (r_hold[6:3] == 4'd2);
        r_addr_hit <= w_good && (r_hold[2:0] == ms_lt_addr);
        for (int i = 0; i < NUM_LT; i++) begin
          if (w_good && (r_hold[2:0] == 3'(i))) begin
            r_flow[i]  <= r_hold[7];
            r_arqn[i]  <= r_hold[8];
            r_seqn[i]  <= r_hold[9];
            r_fss_p[i] <= !r_flow[i] && r_hold[7];
          end
        end
      end
    end
  end

`ifdef BT_HDR_FEC_ERRCNT_EN
  logic       w_corr;
  logic [7:0] r_errcnt;

  assign w_corr = (w_ones_tot != 3'd0) && (w_ones_tot != 3'(FEC_REP));

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz)                                         r_errcnt <= '0;
    else if (w_start)                                  r_errcnt <= '0;
    else if (w_wrap && w_corr && (r_errcnt != 8'hFF)) r_errcnt <= r_errcnt + 8'd1;
  end

  assign fec_errcnt = r_errcnt;
`else
  assign fec_errcnt = 8'h00;
`endif

  assign busy              = (r_state != S_IDLE);
  assign hdr_done_p        = r_done_p;
  assign hdr_good_p        = r_good_p;
  assign lt_addressed      = r_addr_hit;
  assign rx_lt_addr        = r_rx_lt;
  assign rx_type           = r_rx_type;
  assign rx_seqn           = r_rx_seqn;
  assign rx_is_null        = r_is_null;
  assign rx_is_poll        = r_is_poll;
  assign rx_is_fhs         = r_is_fhs;
  assign flow_vec          = r_flow;
  assign arqn_vec          = r_arqn;
  assign seqn_vec          = r_seqn;
  assign flow_stop_start_p = r_fss_p;

endmodule
